sum_to_bitstream: RTL

SUM_TO_BITSTREAM -- requirements
Module: sum_to_bitstream

---
 rtl/sum_to_bitstream.sv | 90 +++++++++
 1 files changed

// File: rtl/sum_to_bitstream.sv
// sum_to_bitstream: converts a per-cycle popcount into a 1-bit stream whose
// density is sum/SCALE. Each cycle the popcount is added to a residue
// accumulator, at most one SCALE is removed per cycle and emitted as a '1'.
// The residue saturates at its maximum and raises a sticky overflow flag.
module sum_to_bitstream #(
  parameter int NUM_INPUTS    = 200,
  parameter int SCALE         = 1,
  parameter int COUNTER_WIDTH = 12,
  localparam int SUM_WIDTH    = $clog2(NUM_INPUTS) + 1
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic                     en,
  input  logic                     clr,
  input  logic [SUM_WIDTH-1:0]     sum,
  output logic                     out_bit,
  output logic [COUNTER_WIDTH-1:0] residue,
  output logic                     overflow
);

  // Parameter legality is enforced at elaboration so an illegal build never produces a netlist.
  if (SCALE < 1) begin : g_bad_scale_low
    $fatal(1, "sum_to_bitstream: SCALE must be >= 1");
  end
  if (SCALE > (2 ** COUNTER_WIDTH) - 1) begin : g_bad_scale_high
    $fatal(1, "sum_to_bitstream: SCALE must be <= 2^COUNTER_WIDTH-1");
  end
  if (COUNTER_WIDTH < SUM_WIDTH) begin : g_bad_width
    $fatal(1, "sum_to_bitstream: COUNTER_WIDTH must be >= SUM_WIDTH");
  end

  // One extra bit keeps residue+sum exact; the compare and the saturation
  // test both happen before anything is truncated back to COUNTER_WIDTH.
  localparam logic [COUNTER_WIDTH:0] SCALE_EXT = (COUNTER_WIDTH + 1)'(SCALE);
  localparam logic [COUNTER_WIDTH:0] MAX_EXT   = {1'b0, {COUNTER_WIDTH{1'b1}}};

  logic [COUNTER_WIDTH-1:0] residue_reg;
  logic [COUNTER_WIDTH-1:0] residue_next;
  logic                     out_bit_reg;
  logic                     out_bit_next;
  logic                     overflow_reg;
  logic                     overflow_next;

  logic [COUNTER_WIDTH:0]   total;
  logic [COUNTER_WIDTH:0]   rem;
  logic                     hit;
  logic                     sat;

  // Accumulate, take off at most one SCALE, then saturate; clr beats en.
  always_comb begin
    total         = {1'b0, residue_reg} + {{(COUNTER_WIDTH + 1 - SUM_WIDTH){1'b0}}, sum};
    hit           = (total >= SCALE_EXT);
    rem           = hit ? (total - SCALE_EXT) : total;
    sat           = (rem > MAX_EXT);
    residue_next  = residue_reg;
    out_bit_next  = 1'b0;
    overflow_next = overflow_reg;
    if (clr) begin
      residue_next  = '0;
      out_bit_next  = 1'b0;
      overflow_next = 1'b0;
    end else if (en) begin
      out_bit_next = hit;
      if (sat) begin
        residue_next  = {COUNTER_WIDTH{1'b1}};
        overflow_next = 1'b1;
      end else begin
        residue_next = rem[COUNTER_WIDTH-1:0];
      end
    end
  end

  // State registers; reset clears everything immediately, without waiting for a clock.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      residue_reg  <= '0;
      out_bit_reg  <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      residue_reg  <= residue_next;
      out_bit_reg  <= out_bit_next;
      overflow_reg <= overflow_next;
    end
  end

  assign residue  = residue_reg;
  assign out_bit  = out_bit_reg;
  assign overflow = overflow_reg;

endmodule
